ram_read_arbiter: RTL and testbench

RAM_READ_ARBITER -- requirements
Module: ram_read_arbiter

---
 rtl/ram_read_arbiter.sv | 115 +++++++++++
 tb/tb_ram_read_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_arbiter.sv
// ram_read_arbiter: shares one RAM read port between the UART and HDR requesters.
// Round-robin grant, one outstanding read, and a watchdog that aborts a lost read.
module ram_read_arbiter #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rd_req,
  input  logic [ADDR_W-1:0] uart_rd_address,
  output logic              uart_ack,
  output logic              uart_rd_data_valid,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_address,
  output logic              hdr_ack,
  output logic              hdr_rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_rd_req,
  output logic [ADDR_W-1:0] ram_rd_address,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              ram_rd_data_valid,
  input  logic              ram_busy,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic GNT_UART = 1'b0;
  localparam logic GNT_HDR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              any_req;
  logic              pick;

  assign any_req = uart_rd_req | hdr_rd_req;
  // On a tie the requester that was not served last wins.
  assign pick = (uart_rd_req & hdr_rd_req) ? ~last_grant_q : hdr_rd_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_UART;
      last_grant_q <= GNT_HDR;
      addr_q       <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ram_busy && any_req) begin
          grant_d = pick;
          addr_d  = pick ? hdr_rd_address : uart_rd_address;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_ack) begin
          cnt_d   = '0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ram_rd_data_valid) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d    = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_rd_req         = (state_q == ISSUE);
  assign ram_rd_address     = addr_q;
  assign timeout_err        = timeout_q;
  assign rd_data            = ram_rd_data;
  assign uart_ack           = ram_ack & (state_q == ISSUE) & (grant_q == GNT_UART);
  assign hdr_ack            = ram_ack & (state_q == ISSUE) & (grant_q == GNT_HDR);
  assign uart_rd_data_valid = ram_rd_data_valid & (state_q == WAIT_DATA) & (grant_q == GNT_UART);
  assign hdr_rd_data_valid  = ram_rd_data_valid & (state_q == WAIT_DATA) & (grant_q == GNT_HDR);

endmodule

// File: tb/tb_ram_read_arbiter.sv
// Testbench for ram_read_arbiter: directed stimulus, expected acks and read data
// queued by the stimulus and checked by an independent negedge monitor.
module tb_ram_read_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 128;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_rd_req, hdr_rd_req;
  logic [ADDR_W-1:0] uart_rd_address, hdr_rd_address;
  logic              uart_ack, hdr_ack, uart_rd_data_valid, hdr_rd_data_valid;
  logic [DATA_W-1:0] rd_data;
  logic              ram_rd_req;
  logic [ADDR_W-1:0] ram_rd_address;
  logic              ram_ack, ram_rd_data_valid, ram_busy;
  logic [DATA_W-1:0] ram_rd_data;
  logic              timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { bit who; logic [ADDR_W-1:0] addr; } ack_t;
  typedef struct { bit who; logic [DATA_W-1:0] data; } dat_t;
  ack_t ack_q[$];
  dat_t dat_q[$];
  ack_t ea;
  dat_t ed;

  ram_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .uart_rd_req(uart_rd_req), .uart_rd_address(uart_rd_address),
    .uart_ack(uart_ack), .uart_rd_data_valid(uart_rd_data_valid),
    .hdr_rd_req(hdr_rd_req), .hdr_rd_address(hdr_rd_address),
    .hdr_ack(hdr_ack), .hdr_rd_data_valid(hdr_rd_data_valid),
    .rd_data(rd_data),
    .ram_rd_req(ram_rd_req), .ram_rd_address(ram_rd_address),
    .ram_ack(ram_ack), .ram_rd_data(ram_rd_data),
    .ram_rd_data_valid(ram_rd_data_valid), .ram_busy(ram_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ack(input bit who, input logic [ADDR_W-1:0] addr);
    ack_t e;
    e.who = who; e.addr = addr;
    ack_q.push_back(e);
  endtask

  task automatic exp_dat(input bit who, input logic [DATA_W-1:0] d);
    dat_t e;
    e.who = who; e.data = d;
    dat_q.push_back(e);
  endtask

  // Monitor: every ack and every requester valid must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_ack || hdr_ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", {uart_ack, hdr_ack}, 2'b00);
        else begin
          ea = ack_q.pop_front();
          check("ack_who", {uart_ack, hdr_ack}, ea.who ? 2'b01 : 2'b10);
          check("ack_addr", ram_rd_address, ea.addr);
        end
      end
      if (uart_rd_data_valid || hdr_rd_data_valid) begin
        if (dat_q.size() == 0) check("unexpected_valid", {uart_rd_data_valid, hdr_rd_data_valid}, 2'b00);
        else begin
          ed = dat_q.pop_front();
          check("valid_who", {uart_rd_data_valid, hdr_rd_data_valid}, ed.who ? 2'b01 : 2'b10);
          check("rd_data", rd_data, ed.data);
        end
      end
    end
  end

  // RAM controller model. mode 0: return data; 1: withhold data, expect timeout; 2: stop after ack.
  task automatic serve(input int ack_dly, input int val_dly, input int mode,
                       input logic [DATA_W-1:0] d, input bit drop, output int waited);
    int t;
    int n;
    t = 0;
    while (ram_rd_req !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    waited = t;
    if (ram_rd_req !== 1'b1) begin
      check("ram_rd_req_wait", ram_rd_req, 1'b1);
      return;
    end
    if (drop) begin
      uart_rd_req = 1'b0;
      hdr_rd_req  = 1'b0;
    end
    repeat (ack_dly) step();
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    if (mode == 2) return;
    if (mode == 1) begin
      n = 0;
      while (timeout_err !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      check("timeout_latency", n, TO);
      check("idle_at_timeout", ram_rd_req, 1'b0);
      step();
      check("timeout_one_cycle", timeout_err, 1'b0);
      return;
    end
    repeat (val_dly) step();
    ram_rd_data       = d;
    ram_rd_data_valid = 1'b1;
    step();
    ram_rd_data_valid = 1'b0;
    ram_rd_data       = '0;
  endtask

  initial begin
    int w;
    logic [DATA_W-1:0] d;
    rst = 1'b1;
    uart_rd_req = 1'b0; hdr_rd_req = 1'b0;
    uart_rd_address = '0; hdr_rd_address = '0;
    ram_ack = 1'b0; ram_rd_data_valid = 1'b0; ram_busy = 1'b0; ram_rd_data = '0;
    repeat (3) step();
    check("rst_ram_rd_req", ram_rd_req, 1'b0);
    check("rst_ram_rd_address", ram_rd_address, '0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_acks", {uart_ack, hdr_ack}, 2'b00);
    rst = 1'b0;
    step();

    // Single UART read, requester drops its request mid-ISSUE.
    uart_rd_address = 25'h70800;
    uart_rd_req = 1'b1;
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp_ack(1'b0, 25'h70800);
    exp_dat(1'b0, d);
    serve(2, 5, 0, d, 1'b1, w);
    check("t1_grant_latency", w, 1);
    step();
    check("t1_no_regrant", ram_rd_req, 1'b0);

    // Both requesting from reset: UART, HDR, UART, HDR back-to-back.
    rst = 1'b1; step(); rst = 1'b0; step();
    uart_rd_address = 25'h0;
    hdr_rd_address  = 25'hE1000;
    uart_rd_req = 1'b1; hdr_rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = {4{32'hC0DE0000 + 32'(k)}};
      exp_ack(k[0], k[0] ? 25'hE1000 : 25'h0);
      exp_dat(k[0], d);
      serve(0, 0, 0, d, 1'b0, w);
      check("b2b_grant_gap", w, 1);
    end
    uart_rd_req = 1'b0; hdr_rd_req = 1'b0;
    step();

    // ram_busy blocks the grant for 10 cycles.
    ram_busy = 1'b1;
    hdr_rd_address = 25'h0123;
    hdr_rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("busy_blocks_req", ram_rd_req, 1'b0);
    end
    ram_busy = 1'b0;
    step();
    check("req_after_busy", ram_rd_req, 1'b1);
    d = 128'hB05E_0000_0000_0000_0000_0000_0000_0001;
    exp_ack(1'b1, 25'h0123);
    exp_dat(1'b1, d);
    serve(0, 1, 0, d, 1'b1, w);
    check("busy_req_present", w, 0);

    // Timeout on a UART read, then a tie goes to HDR.
    uart_rd_address = 25'h55;
    uart_rd_req = 1'b1;
    exp_ack(1'b0, 25'h55);
    serve(1, 0, 1, '0, 1'b1, w);
    uart_rd_address = 25'h66;
    hdr_rd_address  = 25'h77;
    uart_rd_req = 1'b1; hdr_rd_req = 1'b1;
    d = 128'h7777_0000_0000_0000_0000_0000_0000_7777;
    exp_ack(1'b1, 25'h77);
    exp_dat(1'b1, d);
    serve(0, 0, 0, d, 1'b1, w);
    check("post_timeout_gap", w, 1);

    // Valid on the last WAIT_DATA cycle beats the timeout.
    uart_rd_address = 25'h99;
    uart_rd_req = 1'b1;
    d = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    exp_ack(1'b0, 25'h99);
    exp_dat(1'b0, d);
    serve(0, TO - 1, 0, d, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      check("no_timeout_with_valid", timeout_err, 1'b0);
      step();
    end

    // Reset in WAIT_DATA, then a stray valid must be dropped.
    hdr_rd_address = 25'hABC;
    hdr_rd_req = 1'b1;
    exp_ack(1'b1, 25'hABC);
    serve(0, 0, 2, '0, 1'b1, w);
    step(); step();
    check("wait_addr_held", ram_rd_address, 25'hABC);
    rst = 1'b1;
    #1;
    check("async_rst_req", ram_rd_req, 1'b0);
    check("async_rst_addr", ram_rd_address, '0);
    step();
    rst = 1'b0;
    step();
    ram_rd_data = 128'hDEAD;
    ram_rd_data_valid = 1'b1;
    #1;
    check("stray_valid_dropped", {uart_rd_data_valid, hdr_rd_data_valid}, 2'b00);
    step();
    ram_rd_data_valid = 1'b0;
    ram_rd_data = '0;
    step();
    check("stray_no_req", ram_rd_req, 1'b0);

    repeat (3) step();
    check("ack_queue_drained", ack_q.size(), 0);
    check("data_queue_drained", dat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
